// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage driving a req/ack data bus (optional MEM_MISALIGN_TRAP_EN misalignment trap); ports: ALU/store/ctrl in, dmem bus, writeback out, stall/bus_err/exc_misalign out
module mem_access_stage #(
  parameter int XLEN        = 32,
  parameter int RADDR_W     = 5,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [XLEN-1:0]    alu_val_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic               rd_we_i,
  input  logic [XLEN-1:0]    rs2_val_i,
  input  logic               mem_re_i,
  input  logic               mem_we_i,
  input  logic [2:0]         funct3_i,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [XLEN-1:0]    dmem_addr_o,
  output logic [XLEN-1:0]    dmem_wdata_o,
  output logic [3:0]         dmem_be_o,
  input  logic               dmem_ack_i,
  input  logic [XLEN-1:0]    dmem_rdata_i,
  output logic [XLEN-1:0]    rd_val_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic               rd_we_o,
  output logic               stall_o,
  output logic               bus_err_o,
  output logic               exc_misalign_o
);
  localparam int CW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state_q;
  logic              req_q, we_q, err_q;
  logic [XLEN-1:0]   addr_q, wdata_q, ldata_q;
  logic [3:0]        be_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              acc, b_sz, h_sz, mis, to;
  logic [3:0]        be_d;
  logic [XLEN-1:0]   wdata_d, fmt;
  logic [7:0]        lb;
  logic [15:0]       lh;
  assign acc  = mem_re_i | mem_we_i;
  // stores decode only SB/SH explicitly; loads ignore funct3[2] (the unsigned bit) for size
  assign b_sz = mem_we_i ? funct3_i == 3'b000 : funct3_i[1:0] == 2'b00;
  assign h_sz = mem_we_i ? funct3_i == 3'b001 : funct3_i[1:0] == 2'b01;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = acc & (h_sz ? alu_val_i[0] : !b_sz & |alu_val_i[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign be_d    = b_sz ? 4'b0001 << alu_val_i[1:0] : h_sz ? 4'b0011 << {alu_val_i[1], 1'b0} : 4'hF;
  assign wdata_d = b_sz ? {(XLEN/8){rs2_val_i[7:0]}} : h_sz ? {(XLEN/16){rs2_val_i[15:0]}} : rs2_val_i;
  assign lb  = dmem_rdata_i[{off_q, 3'b000} +: 8];
  assign lh  = dmem_rdata_i[{off_q[1], 4'b0000} +: 16];
  assign fmt = f3_q == 3'b000 ? {{(XLEN-8){lb[7]}}, lb} :
               f3_q == 3'b001 ? {{(XLEN-16){lh[15]}}, lh} :
               f3_q == 3'b100 ? {{(XLEN-8){1'b0}}, lb} :
               f3_q == 3'b101 ? {{(XLEN-16){1'b0}}, lh} : dmem_rdata_i;
  // timeout fires in the ACK_TIMEOUT-th BUSY cycle; an ack in that same cycle wins
  assign to  = (ACK_TIMEOUT != 0) && (cnt_q == CW'(ACK_TIMEOUT - 1));
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      ldata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (acc && !mis) begin
          state_q <= BUSY;
          req_q   <= 1'b1;
          we_q    <= mem_we_i;
          addr_q  <= {alu_val_i[XLEN-1:2], 2'b00};
          wdata_q <= wdata_d;
          be_q    <= be_d;
          f3_q    <= funct3_i;
          off_q   <= alu_val_i[1:0];
          cnt_q   <= '0;
        end
        BUSY: if (dmem_ack_i) begin
          ldata_q <= fmt;
          req_q   <= 1'b0;
          state_q <= DONE;
        end else if (to) begin
          ldata_q <= '0;
          req_q   <= 1'b0;
          err_q   <= 1'b1;
          state_q <= DONE;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign dmem_req_o     = req_q;
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_wdata_o   = wdata_q;
  assign dmem_be_o      = be_q;
  assign bus_err_o      = err_q;
  assign exc_misalign_o = mis;
  assign stall_o        = state_q == BUSY || (state_q == IDLE && acc && !mis);
  assign rd_val_o       = (state_q == DONE && !we_q) ? ldata_q : alu_val_i;
  assign rd_addr_o      = rd_addr_i;
  assign rd_we_o        = rd_we_i & !mis & !(state_q == DONE && err_q);
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and randomized checks of mem_access_stage against a behavioural model
module tb_mem_access_stage;
  localparam int TO = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] alu = '0, rs2_val = '0, rdata_in = '0;
  logic [4:0]  rd_addr = '0;
  logic        rd_we = 1'b0, mem_re = 1'b0, mem_we = 1'b0, ack = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        req, we_o, rd_we_o, stall, bus_err, exc;
  logic [31:0] addr, wdata, rd_val;
  logic [3:0]  be;
  logic [4:0]  rd_addr_o;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mem_access_stage #(.XLEN(32), .RADDR_W(5), .ACK_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .alu_val_i(alu), .rd_addr_i(rd_addr), .rd_we_i(rd_we),
    .rs2_val_i(rs2_val), .mem_re_i(mem_re), .mem_we_i(mem_we), .funct3_i(funct3),
    .dmem_req_o(req), .dmem_we_o(we_o), .dmem_addr_o(addr), .dmem_wdata_o(wdata),
    .dmem_be_o(be), .dmem_ack_i(ack), .dmem_rdata_i(rdata_in), .rd_val_o(rd_val),
    .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .stall_o(stall), .bus_err_o(bus_err),
    .exc_misalign_o(exc)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  function automatic int size(input bit st, input logic [2:0] f3);
    if (st) return f3 == 3'd0 ? 1 : f3 == 3'd1 ? 2 : 4;
    return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a[1:0])) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return b[7] ? b | 32'hFFFFFF00 : b;
      3'd1:    return h[15] ? h | 32'hFFFF0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rs2, input logic [31:0] rdata, input int waits);
    int nst;
    bit got, mis;
    logic [31:0] exp_rd;
    logic [4:0] rd;
    rd = 5'($urandom);
    @(negedge clk);
    mem_re = !st; mem_we = st; funct3 = f3; alu = a; rs2_val = rs2; rd_we = 1'b1; rd_addr = rd; ack = 1'b0;
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (a % size(st, f3)) != 0;
`endif
    #1;
    if (mis) begin
      chk("mis_exc", exc, 1);
      chk("mis_stall", stall, 0);
      chk("mis_rdwe", rd_we_o, 0);
      @(posedge clk); #1;
      chk("mis_noreq", req, 0);
    end else begin
      chk("idle_exc", exc, 0);
      chk("idle_stall", stall, 1);
      nst = 1;
      @(posedge clk); #1;
      chk("req", req, 1);
      chk("we", we_o, st);
      chk("addr", addr, a & ~32'h3);
      if (st) begin
        chk("be", be, f3 == 3'd0 ? 32'(1 << a[1:0]) : f3 == 3'd1 ? 32'(3 << (2 * a[1])) : 32'hF);
        chk("wdata", wdata, f3 == 3'd0 ? rs2[7:0] * 32'h01010101 : f3 == 3'd1 ? rs2[15:0] * 32'h00010001 : rs2);
      end
      got = 1'b0;
      for (int i = 0; i < TO && !got; i++) begin
        @(negedge clk);
        ack = (i == waits);
        rdata_in = ack ? rdata : $urandom;
        #1;
        nst += int'(stall);
        chk("busy_req", req, 1);
        @(posedge clk); #1;
        got = ack;
      end
      ack = 1'b0;
      exp_rd = st ? a : got ? ld_model(f3, a, rdata) : 32'h0;
      chk("done_req", req, 0);
      chk("done_stall", stall, 0);
      chk("stall_cycles", nst, got ? waits + 2 : TO + 1);
      chk("bus_err", bus_err, !got);
      chk("rd_we", rd_we_o, got);
      chk("rd_val", rd_val, exp_rd);
      chk("rd_addr", rd_addr_o, rd);
    end
    @(negedge clk);
    mem_re = 1'b0; mem_we = 1'b0;
    @(posedge clk); #1;
    chk("err_clear", bus_err, 0);
    chk("no_reissue", req, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", req, 0);
    chk("rst_we", we_o, 0);
    chk("rst_be", be, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    alu = 32'h1234; rd_addr = 5'd5; rd_we = 1'b1;
    #1;
    chk("alu_pass", rd_val, 32'h1234);
    chk("alu_stall", stall, 0);
    chk("alu_rd", rd_addr_o, 5);
    chk("alu_rdwe", rd_we_o, 1);
    @(posedge clk); #1;
    chk("alu_noreq", req, 0);
    access(1'b1, 3'd0, 32'h103, 32'hAB, 32'h0, 0);
    access(1'b0, 3'd0, 32'h102, 32'h0, 32'h0080FF00, 3);
    access(1'b0, 3'd4, 32'h102, 32'h0, 32'h0080FF00, 3);
    access(1'b0, 3'd2, 32'h200, 32'h0, 32'h12345678, 10);
    access(1'b1, 3'd1, 32'h302, 32'h5A5AC3C3, 32'h0, 1);
    access(1'b0, 3'd2, 32'h102, 32'h0, 32'hCAFEBABE, 1);
    @(negedge clk);
    mem_re = 1'b1; funct3 = 3'd2; alu = 32'h400;
    @(posedge clk); #1;
    chk("mid_req", req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_req", req, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_re = 1'b0; ack = 1'b1; rdata_in = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("late_ack_req", req, 0);
    chk("late_ack_err", bus_err, 0);
    chk("late_ack_stall", stall, 0);
    chk("late_ack_val", rd_val, 32'h400);
    @(negedge clk);
    ack = 1'b0;
    for (int n = 0; n < 40; n++)
      access(1'($urandom), 3'($urandom), $urandom & 32'hFFFF, $urandom, $urandom, int'($urandom_range(0, 5)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
